// File: rtl/led_sequence_player.sv
// Plays entries 0..len-1 of the Genius sequence memory on four LEDs, with a blank gap after each.
// Optional: define SEQ_PLAYER_ABORT_EN to let abort cancel a playback in progress.
module led_sequence_player #(
  parameter int CLK_FREQ = 200,
  parameter int MAX_LEN  = 32,
  parameter int AW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    length,
  input  logic          speed_game,
  input  logic [3:0]    seq_data,
  input  logic          abort,
  output logic [AW-1:0] seq_addr,
  output logic [3:0]    leds,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [31:0] T_FAST = (CLK_FREQ / 2 >= 1) ? 32'(CLK_FREQ / 2) : 32'd1;
  localparam logic [31:0] T_SLOW = (2 * CLK_FREQ >= 1) ? 32'(2 * CLK_FREQ) : 32'd1;
  localparam logic [31:0] T_GAP  = (CLK_FREQ / 4 >= 1) ? 32'(CLK_FREQ / 4) : 32'd1;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic          speed_q, speed_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   timer_q, timer_d;
  logic          first_q, first_d;
  logic [3:0]    leds_q, leds_d;

  logic [AW:0]   len_clamp;
  logic [31:0]   t_on;
  logic [31:0]   timer_dec;
  logic          last_entry;
  logic          abort_hit;

`ifdef SEQ_PLAYER_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  assign len_clamp  = (int'(length) > MAX_LEN) ? (AW+1)'(MAX_LEN) : (AW+1)'(length);
  assign t_on       = speed_q ? T_FAST : T_SLOW;
  assign timer_dec  = (timer_q == '0) ? '0 : timer_q - 32'd1;
  assign last_entry = ({1'b0, idx_q} == (len_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      speed_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      timer_q <= '0;
      first_q <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      speed_q <= speed_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
      first_q <= first_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    speed_d = speed_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    first_d = 1'b0;
    leds_d  = leds_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          speed_d = speed_game;
          idx_d   = '0;
          addr_d  = '0;
          state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_ON;
        timer_d = t_on - 32'd1;
        first_d = 1'b1;
      end
      S_ON: begin
        // Memory data arrives in the first ON cycle; it is shown live then and held afterwards.
        if (first_q) leds_d = seq_data;
        timer_d = timer_dec;
        if (timer_q == '0) begin
          state_d = S_GAP;
          timer_d = T_GAP - 32'd1;
        end
      end
      S_GAP: begin
        timer_d = timer_dec;
        if (timer_q == '0) begin
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_hit && busy) begin
      state_d = S_IDLE;
      addr_d  = '0;
      first_d = 1'b0;
    end
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_ON) || (state_q == S_GAP);
  assign done     = (state_q == S_DONE);
  assign seq_addr = addr_q;
  assign leds     = (state_q == S_ON) ? (first_q ? seq_data : leds_q) : '0;

endmodule

// File: tb/tb_led_sequence_player.sv
// Randomized bench for led_sequence_player; expected LED/busy/done/address per cycle come from
// the entry-period arithmetic (entry = k / period, phase = k % period).
module tb_led_sequence_player;

  localparam int TON_FAST = 100;
  localparam int TON_SLOW = 400;
  localparam int TG       = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] length;
  logic       speed_game;
  logic [3:0] seq_data;
  logic       abort;
  logic [4:0] seq_addr;
  logic [3:0] leds;
  logic       busy;
  logic       done;

  logic [3:0] mem [0:31];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) seq_data <= mem[seq_addr];

  led_sequence_player #(.CLK_FREQ(200), .MAX_LEN(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .length    (length),
    .speed_game(speed_game),
    .seq_data  (seq_data),
    .abort     (abort),
    .seq_addr  (seq_addr),
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k = number of clock edges since (and including) the edge that sampled start, minus one.
  task automatic play(input int len_in, input bit spd, input int repulse_at,
                      input int abort_at, input int rst_at);
    int n, ton, per, total, last_k, done_cnt, done_cyc, max_addr, e, o, exp_leds, exp_addr;
    bit ab, exp_busy, exp_done;
    n   = (len_in > 32) ? 32 : len_in;
    ton = spd ? TON_FAST : TON_SLOW;
    per = 1 + ton + TG;
    total = n * per;
`ifdef SEQ_PLAYER_ABORT_EN
    ab = (abort_at > 0);
`else
    ab = 1'b0;
`endif
    last_k   = ab ? abort_at + 6 : total + 3;
    done_cnt = 0;
    done_cyc = -1;
    max_addr = 0;

    @(negedge clk);
    length     = 6'(len_in);
    speed_game = spd;
    start      = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= last_k; k++) begin
      if (k == rst_at) begin
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #1;
        check($sformatf("rst_leds@%0d", k), int'(leds), 0);
        check($sformatf("rst_busy@%0d", k), int'(busy), 0);
        check($sformatf("rst_addr@%0d", k), int'(seq_addr), 0);
        check($sformatf("rst_done@%0d", k), int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check($sformatf("post_rst_done@%0d", j), int'(done), 0);
          check($sformatf("post_rst_busy@%0d", j), int'(busy), 0);
        end
        return;
      end

      exp_leds = 0;
      exp_addr = -1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (ab && k > abort_at) begin
        exp_busy = 1'b0;
      end else if (k < total) begin
        e = k / per;
        o = k % per;
        exp_busy = 1'b1;
        if (o == 0) exp_addr = e;
        if (o >= 1 && o <= ton) exp_leds = int'(mem[e]);
      end else if (k == total) begin
        exp_done = 1'b1;
      end

      check($sformatf("leds@%0d", k), int'(leds), exp_leds);
      check($sformatf("busy@%0d", k), int'(busy), int'(exp_busy));
      check($sformatf("done@%0d", k), int'(done), int'(exp_done));
      if (exp_addr >= 0) check($sformatf("addr@%0d", k), int'(seq_addr), exp_addr);
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (busy && int'(seq_addr) > max_addr) max_addr = int'(seq_addr);

      length     = 6'($urandom_range(0, 63));
      speed_game = 1'($urandom);
      start      = (k == repulse_at);
      abort      = (k == abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    if (ab) begin
      check("abort_done_cnt", done_cnt, 0);
    end else begin
      check("done_cnt", done_cnt, 1);
      check("done_cyc", done_cyc, total);
      check("max_addr", max_addr, (n == 0) ? 0 : n - 1);
    end
  endtask

  task automatic load_123;
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
  endtask

  task automatic load_random;
    for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(1, 15));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    length     = '0;
    speed_game = 1'b0;
    abort      = 1'b0;
    load_123();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_leds", int'(leds), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(seq_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    play(3, 1'b1, -1, -1, -1);

    mem[0] = 4'b1000;
    play(1, 1'b0, -1, -1, -1);

    play(0, 1'b1, -1, -1, -1);

    load_random();
    play(40, 1'b1, -1, -1, -1);

    load_123();
    play(3, 1'b1, 181, -1, -1);

    play(3, 1'b1, -1, -1, 50);

    for (int r = 0; r < 3; r++) begin
      load_random();
      play($urandom_range(1, 3), 1'($urandom), -1, -1, -1);
    end

    load_123();
    play(3, 1'b1, -1, 120, -1);
    play(2, 1'b1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
